// File: rtl/fp_norm_pkg.sv
// ---------------------------------------------------------------------------
// fp_norm_pkg
//   Shared definitions for the mantissa normalizer slice:
//     - state_t   : normalizer FSM states (IDLE, SHIFT, DONE)
//     - MANT_W_DEF: default mantissa width including the hidden bit
//     - EXP_W_DEF : default biased exponent width
//     - LZC_W     : width of the leading-zero count bus
//     - LZC_ZERO  : leading-zero count that denotes an all-zero mantissa
// ---------------------------------------------------------------------------
package fp_norm_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int LZC_W      = 5;
  localparam int LZC_ZERO   = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : fp_norm_pkg

// File: rtl/fp_lzc24.sv
// ---------------------------------------------------------------------------
// fp_lzc24
//   Combinational reference leading-zero counter used to cross-check the
//   count supplied by the upstream encoder. An all-zero mantissa reports
//   MANT_W (24 by default).
//   Only compiled when FP_NORM_LZC_CHECK_EN is defined; the default build
//   has no use for it.
//
//   Ports:
//     mant  input  MANT_W  mantissa to examine
//     lzc   output LZC_W   number of leading zeros (MANT_W when mant == 0)
// ---------------------------------------------------------------------------
`ifdef FP_NORM_LZC_CHECK_EN
module fp_lzc24
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [MANT_W-1:0] mant,
  output logic [LZC_W-1:0]  lzc
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) begin
        lzc = LZC_W'(MANT_W - 1 - i);
      end
    end
  end

endmodule : fp_lzc24
`endif

// File: rtl/fp_mant_normalizer.sv
// ---------------------------------------------------------------------------
// fp_mant_normalizer
//   Normalizes a mantissa coming out of the add/sub datapath. The mantissa is
//   shifted left over several cycles (at most STEP bits per cycle) until its
//   top bit is set, while the exponent is reduced by the same amount. The
//   shift is clamped so the exponent never drops below 1; if the requested
//   shift would reach or pass the denormal boundary the result is flagged as
//   underflow and reported with exponent 0. Zero mantissas bypass the shifter.
//   One transaction is in flight at a time.
//
//   Optional feature (macro FP_NORM_LZC_CHECK_EN): recompute the leading-zero
//   count of the accepted mantissa and raise out_lzc_err in DONE when it
//   disagrees with min(in_lzc, 24). Without the macro out_lzc_err is 0.
//
//   Ports:
//     clk          input   1       rising-edge clock
//     rst          input   1       synchronous active-high reset
//     in_valid     input   1       input transaction present
//     in_ready     output  1       high only in IDLE
//     in_mant      input   MANT_W  unnormalized mantissa
//     in_exp       input   EXP_W   biased exponent
//     in_lzc       input   5       leading-zero count (24..31 = zero)
//     out_valid    output  1       result held valid (DONE)
//     out_ready    input   1       downstream accepts
//     out_mant     output  MANT_W  normalized / denormal mantissa
//     out_exp      output  EXP_W   adjusted exponent, 0 for denormal/zero
//     out_zero     output  1       result is zero
//     out_uflow    output  1       shift clamped at the denormal boundary
//     out_lzc_err  output  1       supplied lzc disagrees with the mantissa
// ---------------------------------------------------------------------------
module fp_mant_normalizer
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [LZC_W-1:0]  in_lzc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow,
  output logic              out_lzc_err
);

  // Remaining-shift counter width; STEP <= MANT_W also fits.
  localparam int RW = $clog2(MANT_W + 1);
  // Common width for comparing the lzc against the exponent.
  localparam int CW = (EXP_W > LZC_W) ? EXP_W : LZC_W;
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic [RW-1:0]     rem_q;
  logic              zero_q;
  logic              uflow_q;
  logic              lzc_err_q;

  // -------------------------------------------------------------------------
  // Input classification (only meaningful while IDLE)
  // -------------------------------------------------------------------------
  logic [CW-1:0]    lzc_w, exp_w, expm1_w, sh_w;
  logic             is_zero, is_uflow;
  logic [EXP_W-1:0] exp_fin;
  logic             lzc_err_d;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    lzc_w    = CW'(in_lzc);
    exp_w    = CW'(in_exp);
    expm1_w  = exp_w - CW'(1);
    is_zero  = (in_lzc >= LZC_W'(LZC_ZERO)) || (in_mant == '0);
    // Shift stops one short of the exponent so the result exponent stays >= 1.
    if (exp_w == '0) begin
      sh_w = '0;
    end else if (lzc_w < expm1_w) begin
      sh_w = lzc_w;
    end else begin
      sh_w = expm1_w;
    end
    is_uflow = (exp_w != '0) && (lzc_w >= exp_w);
    exp_fin  = is_uflow ? '0 : (in_exp - EXP_W'(sh_w));
  end

`ifdef FP_NORM_LZC_CHECK_EN
  logic [LZC_W-1:0] lzc_calc;
  logic [LZC_W-1:0] lzc_sat;

  fp_lzc24 #(
    .MANT_W (MANT_W)
  ) u_lzc (
    .mant (in_mant),
    .lzc  (lzc_calc)
  );

  // Encoder codes 24..31 all mean "zero", so compare against the saturated value.
  assign lzc_sat   = (in_lzc > LZC_W'(LZC_ZERO)) ? LZC_W'(LZC_ZERO) : in_lzc;
  assign lzc_err_d = (lzc_calc != lzc_sat);
`else
  assign lzc_err_d = 1'b0;
`endif

  // Per-cycle shift amount: a full STEP, or whatever is left.
  logic [RW-1:0] step_amt;
  assign step_amt = (rem_q < STEP_R) ? rem_q : STEP_R;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (is_zero || (sh_w == '0)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q <= STEP_R) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: capture on accept, shift in SHIFT, hold in DONE/IDLE
  // -------------------------------------------------------------------------
  // NOTE: the datapath registers are reset as well as the FSM because they
  // drive the result ports directly, which must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mant_q    <= '0;
      exp_q     <= '0;
      rem_q     <= '0;
      zero_q    <= 1'b0;
      uflow_q   <= 1'b0;
      lzc_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            lzc_err_q <= lzc_err_d;
            if (is_zero) begin
              mant_q  <= '0;
              exp_q   <= '0;
              rem_q   <= '0;
              zero_q  <= 1'b1;
              uflow_q <= 1'b0;
            end else begin
              mant_q  <= in_mant;
              exp_q   <= exp_fin;
              rem_q   <= RW'(sh_w);
              zero_q  <= 1'b0;
              uflow_q <= is_uflow;
            end
          end
        end
        SHIFT: begin
          mant_q <= mant_q << step_amt;
          rem_q  <= rem_q - step_amt;
        end
        default: ;
      endcase
    end
  end

  assign out_mant    = mant_q;
  assign out_exp     = exp_q;
  assign out_zero    = zero_q;
  assign out_uflow   = uflow_q;
  assign out_lzc_err = lzc_err_q;

endmodule : fp_mant_normalizer

// File: tb/tb_fp_mant_normalizer.sv
// ---------------------------------------------------------------------------
// tb_fp_mant_normalizer
//   Self-checking bench for fp_mant_normalizer (STEP = 4): a table of
//   directed vectors, hand-written backpressure and reset-abort sequences,
//   and randomized transactions compared against an arithmetic reference
//   model. Honours FP_NORM_LZC_CHECK_EN for the out_lzc_err expectation.
// ---------------------------------------------------------------------------
module tb_fp_mant_normalizer;

  localparam int STEP = 4;

`ifdef FP_NORM_LZC_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic [4:0]  in_lzc;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uflow;
  logic        out_lzc_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uflow;
    logic        err;
    logic [7:0]  lat;
  } res_t;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [4:0]  lzc;
    res_t        want;
  } vec_t;

  fp_mant_normalizer #(
    .MANT_W (24),
    .EXP_W  (8),
    .STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_exp      (in_exp),
    .in_lzc      (in_lzc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mant    (out_mant),
    .out_exp     (out_exp),
    .out_zero    (out_zero),
    .out_uflow   (out_uflow),
    .out_lzc_err (out_lzc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // True leading-zero count, scanning from the MSB down.
  function automatic int true_lzc(logic [23:0] m);
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) return 23 - i;
    end
    return 24;
  endfunction

  // Reference model: straight arithmetic on the classification rules.
  function automatic res_t model(logic [23:0] m, logic [7:0] e, logic [4:0] l);
    res_t r;
    int   li, ei, sh;
    li = int'(l);
    ei = int'(e);
    r.err = CHK_EN && (true_lzc(m) != ((li > 24) ? 24 : li));
    if (li >= 24 || m == 0) begin
      r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0; r.lat = 8'd1;
      return r;
    end
    if (ei == 0)           sh = 0;
    else if (li < ei - 1)  sh = li;
    else                   sh = ei - 1;
    r.zero  = 1'b0;
    r.uflow = (ei != 0) && (li >= ei);
    r.exp   = r.uflow ? 8'd0 : 8'(ei - sh);
    r.mant  = 24'(m << sh);
    r.lat   = 8'(1 + (sh + STEP - 1) / STEP);
    return r;
  endfunction

  // Runs one transaction with out_ready held high. Entered and left just
  // after a rising edge. Latency counts cycles from the accept edge.
  task automatic run_txn(input logic [23:0] m, input logic [7:0] e, input logic [4:0] l,
                         output res_t r);
    int n;
    r = '0;
    in_mant  = m;
    in_exp   = e;
    in_lzc   = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Garbage on the data inputs must be ignored outside IDLE.
    in_mant = 24'($urandom);
    in_exp  = 8'($urandom);
    in_lzc  = 5'($urandom);
    r.lat = 8'd1;
    @(negedge clk);
    while (!out_valid && r.lat < 100) begin
      @(negedge clk);
      r.lat++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      return;
    end
    r.mant  = out_mant;
    r.exp   = out_exp;
    r.zero  = out_zero;
    r.uflow = out_uflow;
    r.err   = out_lzc_err;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input res_t got, input res_t want);
    check({tag, ".mant"},  32'(got.mant),  32'(want.mant));
    check({tag, ".exp"},   32'(got.exp),   32'(want.exp));
    check({tag, ".zero"},  32'(got.zero),  32'(want.zero));
    check({tag, ".uflow"}, 32'(got.uflow), 32'(want.uflow));
    check({tag, ".lzc_err"}, 32'(got.err), 32'(want.err));
    check({tag, ".latency"}, 32'(got.lat), 32'(want.lat));
  endtask

  initial begin
    vec_t        vecs[12];
    res_t        got, want;
    res_t        snap;
    logic [23:0] m;
    logic [7:0]  e;
    logic [4:0]  l;
    bit          saw_valid;
    int          k;

    // {mant, exp, lzc, {out_mant, out_exp, zero, uflow, lzc_err(if checker), latency}}
    vecs[0]  = '{24'h000F00, 8'd100, 5'd12, '{24'hF00000, 8'd88,  1'b0, 1'b0, 1'b0, 8'd4}};
    vecs[1]  = '{24'h800001, 8'd127, 5'd0,  '{24'h800001, 8'd127, 1'b0, 1'b0, 1'b0, 8'd1}};
    vecs[2]  = '{24'h000100, 8'd5,   5'd15, '{24'h001000, 8'd0,   1'b0, 1'b1, 1'b0, 8'd2}};
    vecs[3]  = '{24'h000000, 8'd77,  5'd24, '{24'h000000, 8'd0,   1'b1, 1'b0, 1'b0, 8'd1}};
    vecs[4]  = '{24'h000123, 8'd0,   5'd15, '{24'h000123, 8'd0,   1'b0, 1'b0, 1'b0, 8'd1}};
    vecs[5]  = '{24'h000001, 8'd200, 5'd23, '{24'h800000, 8'd177, 1'b0, 1'b0, 1'b0, 8'd7}};
    vecs[6]  = '{24'h000800, 8'd1,   5'd12, '{24'h000800, 8'd0,   1'b0, 1'b1, 1'b0, 8'd1}};
    vecs[7]  = '{24'h000800, 8'd12,  5'd12, '{24'h400000, 8'd0,   1'b0, 1'b1, 1'b0, 8'd4}};
    vecs[8]  = '{24'h000800, 8'd13,  5'd12, '{24'h800000, 8'd1,   1'b0, 1'b0, 1'b0, 8'd4}};
    vecs[9]  = '{24'h00FFFF, 8'd50,  5'd4,  '{24'h0FFFF0, 8'd46,  1'b0, 1'b0, 1'b1, 8'd2}};
    vecs[10] = '{24'h123456, 8'd9,   5'd30, '{24'h000000, 8'd0,   1'b1, 1'b0, 1'b1, 8'd1}};
    vecs[11] = '{24'h0FFFFF, 8'd3,   5'd4,  '{24'h3FFFFC, 8'd0,   1'b0, 1'b1, 1'b0, 8'd2}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_lzc    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset.in_ready",  32'(in_ready),    32'd1);
    check("reset.out_valid", 32'(out_valid),   32'd0);
    check("reset.out_mant",  32'(out_mant),    32'd0);
    check("reset.out_exp",   32'(out_exp),     32'd0);
    check("reset.out_zero",  32'(out_zero),    32'd0);
    check("reset.out_uflow", 32'(out_uflow),   32'd0);
    check("reset.lzc_err",   32'(out_lzc_err), 32'd0);
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      want     = vecs[i].want;
      want.err = CHK_EN ? vecs[i].want.err : 1'b0;
      run_txn(vecs[i].mant, vecs[i].exp, vecs[i].lzc, got);
      compare($sformatf("vec%0d", i), got, want);
    end

    // Backpressure: hold DONE for 5 cycles, then release with a new input pending
    out_ready = 1'b0;
    in_mant   = 24'h000F00;
    in_exp    = 8'd100;
    in_lzc    = 5'd12;
    in_valid  = 1'b1;
    @(negedge clk);
    check("bp.accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp.reached_done", 32'(out_valid), 32'd1);
    snap = {out_mant, out_exp, out_zero, out_uflow, out_lzc_err, 8'd0};
    check("bp.mant", 32'(out_mant), 32'hF00000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d.valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp.hold%0d.outputs", c),
            32'({out_mant, out_exp} ^ {snap.mant, snap.exp}) |
            32'({out_zero, out_uflow, out_lzc_err} ^ {snap.zero, snap.uflow, snap.err}),
            32'd0);
    end
    out_ready = 1'b1;
    in_mant   = 24'h800001;
    in_exp    = 8'd127;
    in_lzc    = 5'd0;
    in_valid  = 1'b1;
    @(posedge clk);                 // DONE handshake
    @(negedge clk);
    check("bp.release.in_ready",  32'(in_ready),  32'd1);
    check("bp.release.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);                 // accept of the queued input
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.next.valid", 32'(out_valid), 32'd1);
    check("bp.next.mant",  32'(out_mant),  32'h800001);
    check("bp.next.exp",   32'(out_exp),   32'd127);
    @(posedge clk);
    #1;

    // Reset during SHIFT aborts the transaction
    in_mant  = 24'h000008;
    in_exp   = 8'd100;
    in_lzc   = 5'd20;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_abort.accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_abort.in_shift", 32'(in_ready | out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort.out_valid", 32'(out_valid), 32'd0);
    check("rst_abort.in_ready",  32'(in_ready),  32'd1);
    check("rst_abort.out_mant",  32'(out_mant),  32'd0);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_abort.no_stale", 32'(saw_valid), 32'd0);
    @(posedge clk);
    #1;

    // Randomized transactions against the reference model
    for (int t = 0; t < 300; t++) begin
      k = int'($urandom_range(0, 25));
      if (k >= 24) m = '0;
      else         m = (24'($urandom) | 24'h800000) >> k;
      l = 5'(true_lzc(m));
      case ($urandom_range(0, 7))
        0: l = 5'($urandom_range(24, 31));
        1: l = 5'($urandom_range(0, 31));
        default: ;
      endcase
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      want = model(m, e, l);
      run_txn(m, e, l, got);
      compare($sformatf("rand%0d", t), got, want);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fp_mant_normalizer
